// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Purpose:
//   This module sits between a requester and an external combinational ALU.
//   It accepts one operation at a time. It holds the latched op code and
//   operands on the ALU inputs for as long as the op needs: one cycle for
//   simple ops, MULDIV_CYCLES cycles for MUL and DIV. It then captures the
//   ALU result and holds it until the consumer takes it.
//
// Parameters:
//   MULDIV_CYCLES  Cycles the ALU inputs are held for MUL/DIV (legal 1..16).
//
// Optional feature (macro ALU_SEQ_DIVZERO_TRAP_EN):
//   When this macro is defined, a DIV with B==0 does not use the ALU. It
//   completes after one cycle with a zero result and div_zero=1. When the
//   macro is undefined, such a DIV runs as a normal DIV and div_zero is
//   tied to 0.
//
// Ports:
//   clock       in   1   Single clock, rising edge.
//   clear       in   1   Asynchronous active-high reset.
//   req_valid   in   1   Request valid.
//   req_ready   out  1   Sequencer idle and able to accept a request.
//   req_op      in   5   ALU op code (00000 ADD .. 01100 SUB).
//   req_a/b     in   32  Operands.
//   alu_ops     out  5   Op code driven to the ALU (latched).
//   alu_a/b     out  32  Operands driven to the ALU (latched).
//   alu_z       in   64  ALU result.
//   res_valid   out  1   A result is held.
//   res_ready   in   1   Consumer takes the result.
//   res_lo/hi   out  32  Captured result halves.
//   busy        out  1   High in any state except IDLE.
//   illegal_op  out  1   The held result came from an op code above 01100.
//   div_zero    out  1   The held result came from a trapped DIV by zero.
// -----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [4:0]  alu_ops,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [63:0] alu_z,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_lo,
  output logic [31:0] res_hi,
  output logic        busy,
  output logic        illegal_op,
  output logic        div_zero
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXEC   = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  localparam logic [4:0] OP_MUL  = 5'b00101;
  localparam logic [4:0] OP_DIV  = 5'b01011;
  localparam logic [4:0] OP_LAST = 5'b01100;

  // The counter is loaded on accept. EXEC and WAIT each spend one cycle per
  // count. The capture happens on the edge where the count is already 0, so
  // the result appears exactly MULDIV_CYCLES edges after the accept.
  localparam logic [3:0] CNT_LOAD = 4'(MULDIV_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [4:0]  op_q,    op_d;
  logic [31:0] a_q,     a_d;
  logic [31:0] b_q,     b_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [31:0] lo_q,    lo_d;
  logic [31:0] hi_q,    hi_d;
  logic        ill_q,   ill_d;

  logic op_illegal;
  logic op_muldiv;

  assign op_illegal = (op_q > OP_LAST);
  assign op_muldiv  = (op_q == OP_MUL) || (op_q == OP_DIV);

`ifdef ALU_SEQ_DIVZERO_TRAP_EN
  logic divz_q, divz_d;
  logic div_by_zero;
  assign div_by_zero = (op_q == OP_DIV) && (b_q == 32'd0);
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    ill_d   = ill_q;
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
    divz_d  = divz_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          cnt_d   = CNT_LOAD;
          ill_d   = 1'b0;
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
          divz_d  = 1'b0;
`endif
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (op_illegal) begin
          // The ALU output has no meaning for unknown op codes, so it is ignored.
          lo_d    = 32'd0;
          hi_d    = 32'd0;
          ill_d   = 1'b1;
          state_d = ST_RESULT;
        end
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
        else if (div_by_zero) begin
          lo_d    = 32'd0;
          hi_d    = 32'd0;
          divz_d  = 1'b1;
          state_d = ST_RESULT;
        end
`endif
        else if (op_muldiv) begin
          if (cnt_q == 4'd0) begin
            lo_d    = alu_z[31:0];
            hi_d    = alu_z[63:32];
            state_d = ST_RESULT;
          end else begin
            cnt_d   = cnt_q - 4'd1;
            state_d = ST_WAIT;
          end
        end else begin
          // Simple ops return only the low word.
          lo_d    = alu_z[31:0];
          hi_d    = 32'd0;
          state_d = ST_RESULT;
        end
      end

      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          lo_d    = alu_z[31:0];
          hi_d    = alu_z[63:32];
          state_d = ST_RESULT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESULT: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      op_q    <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      cnt_q   <= 4'd0;
      lo_q    <= 32'd0;
      hi_q    <= 32'd0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      ill_q   <= ill_d;
    end
  end

`ifdef ALU_SEQ_DIVZERO_TRAP_EN
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      divz_q <= 1'b0;
    end else begin
      divz_q <= divz_d;
    end
  end
  assign div_zero = divz_q;
`else
  assign div_zero = 1'b0;
`endif

  // The handshake and status outputs are decoded from the state. They
  // therefore follow clear at once, without waiting for a clock edge.
  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign res_valid  = (state_q == ST_RESULT);
  assign alu_ops    = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign res_lo     = lo_q;
  assign res_hi     = hi_q;
  assign illegal_op = ill_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Testbench for alu_sequencer. A behavioural ALU drives alu_z from the
// sequencer's ALU outputs. For each request, a reference model works out the
// latency, result halves and flags from the op code and operands. The bench
// runs directed cases first and then a batch of random requests.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

  localparam int unsigned M = 4;

`ifdef ALU_SEQ_DIVZERO_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic        clock;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  alu_ops;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [63:0] alu_z;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_lo;
  logic [31:0] res_hi;
  logic        busy;
  logic        illegal_op;
  logic        div_zero;

  int n_checks = 0;
  int n_fails  = 0;

  alu_sequencer #(.MULDIV_CYCLES(M)) dut (
    .clock      (clock),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_ops    (alu_ops),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_z      (alu_z),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_lo     (res_lo),
    .res_hi     (res_hi),
    .busy       (busy),
    .illegal_op (illegal_op),
    .div_zero   (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural ALU. The high word is deliberately non-zero for simple ops.
  function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      5'd0:    return {32'hDEAD_BEEF, a + b};
      5'd12:   return {~a, a - b};
      5'd5:    return 64'(a) * 64'(b);
      5'd11:   return (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: return {a ^ b, a + (b ^ {27'd0, op})};
    endcase
  endfunction

  always_comb alu_z = alu_fn(alu_ops, alu_a, alu_b);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues one request and follows it through to the handshake, checking it
  // against the reference model.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [63:0] z;
    int          lat;
    logic [31:0] elo;
    logic [31:0] ehi;
    logic        eill;
    logic        edz;

    z    = alu_fn(op, a, b);
    eill = 1'b0;
    edz  = 1'b0;
    if (op > 5'd12) begin
      lat = 1; elo = 0; ehi = 0; eill = 1'b1;
    end else if (Trap && op == 5'd11 && b == 0) begin
      lat = 1; elo = 0; ehi = 0; edz = 1'b1;
    end else if (op == 5'd5 || op == 5'd11) begin
      lat = M; elo = z[31:0]; ehi = z[63:32];
    end else begin
      lat = 1; elo = z[31:0]; ehi = 0;
    end

    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clock); #1;
    // While busy, the request inputs are junk and must be ignored.
    req_valid = 1'($urandom);
    req_op    = 5'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
    chk("busy_exec", 64'(busy), 64'd1);
    chk("req_ready_exec", 64'(req_ready), 64'd0);
    chk("res_valid_exec", 64'(res_valid), 64'd0);
    chk("flag_clr_ill", 64'(illegal_op), 64'd0);
    chk("flag_clr_dz", 64'(div_zero), 64'd0);

    for (int i = 1; i < lat; i++) begin
      chk("alu_ops_hold", 64'(alu_ops), 64'(op));
      chk("alu_a_hold", 64'(alu_a), 64'(a));
      chk("alu_b_hold", 64'(alu_b), 64'(b));
      res_ready = 1'($urandom);
      @(posedge clock); #1;
      chk("res_valid_early", 64'(res_valid), 64'd0);
      chk("busy_wait", 64'(busy), 64'd1);
    end
    res_ready = 1'($urandom);
    @(posedge clock); #1;
    res_ready = 1'b0;
    chk("res_valid", 64'(res_valid), 64'd1);
    chk("res_lo", 64'(res_lo), 64'(elo));
    chk("res_hi", 64'(res_hi), 64'(ehi));
    chk("illegal_op", 64'(illegal_op), 64'(eill));
    chk("div_zero", 64'(div_zero), 64'(edz));
    chk("alu_ops_res", 64'(alu_ops), 64'(op));

    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_lo", 64'(res_lo), 64'(elo));
      chk("hold_hi", 64'(res_hi), 64'(ehi));
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end

    req_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clock); #1;
    res_ready = 1'b0;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_req_ready", 64'(req_ready), 64'd1);
    chk("idle_res_valid", 64'(res_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          r;

    clear     = 1'b1;
    req_valid = 1'b1;
    req_op    = 5'd3;
    req_a     = 32'h1234;
    req_b     = 32'h5678;
    res_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_lo", 64'(res_lo), 64'd0);
    chk("rst_hi", 64'(res_hi), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_alu_ops", 64'(alu_ops), 64'd0);
    chk("rst_flags", 64'({illegal_op, div_zero}), 64'd0);
    req_valid = 1'b0;
    clear     = 1'b0;

    run_op(5'd0, 32'd5, 32'd7, 0);                    // ADD
    run_op(5'd5, 32'h0001_0000, 32'h0001_0000, 1);   // MUL
    run_op(5'd12, 32'd100, 32'd33, 5);               // SUB held
    run_op(5'd31, 32'hFFFF, 32'h1, 0);               // illegal
    run_op(5'd11, 32'd9, 32'd0, 0);                  // DIV by zero
    run_op(5'd11, 32'd100, 32'd7, 0);                // DIV normal

    // Assert clear between edges while a MUL is in WAIT.
    req_valid = 1'b1;
    req_op    = 5'd5;
    req_a     = 32'd3;
    req_b     = 32'd4;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #2;
    clear = 1'b1;
    #1;
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_res_valid", 64'(res_valid), 64'd0);
    chk("clr_req_ready", 64'(req_ready), 64'd1);
    chk("clr_alu_ops", 64'(alu_ops), 64'd0);
    chk("clr_alu_b", 64'(alu_b), 64'd0);
    #1;
    clear = 1'b0;
    run_op(5'd0, 32'd20, 32'd22, 0);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      case (r)
        0, 1:    op = 5'd0;
        2:       op = 5'd12;
        3:       op = 5'd5;
        4, 5: begin
          op = 5'd11;
          if ($urandom_range(0, 2) == 0) b = 32'd0;
        end
        6, 7:    op = 5'($urandom_range(0, 12));
        default: op = 5'($urandom_range(13, 31));
      endcase
      run_op(op, a, b, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
